// File: rtl/mem_wb_multi.sv
// rtl/mem_wb_multi.sv - multi-channel MEM/WB pipeline register with flush, collision resolution and retire counter
module mem_wb_multi #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NCH     = 2,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int RET_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [NCH-1:0]          mem_valid,
  input  logic [NCH*ADDR_W-1:0]   mem_wd,
  input  logic [NCH-1:0]          mem_wreg,
  input  logic [NCH*DATA_W-1:0]   mem_wdata,
  input  logic                    mem_whilo,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  input  logic                    mem_llbit_we,
  input  logic                    mem_llbit_value,
  input  logic [CNT_W-1:0]        cnt_i,
  output logic [NCH-1:0]          wb_valid,
  output logic [NCH*ADDR_W-1:0]   wb_wd,
  output logic [NCH-1:0]          wb_wreg,
  output logic [NCH*DATA_W-1:0]   wb_wdata,
  output logic                    wb_whilo,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo,
  output logic                    wb_llbit_we,
  output logic                    wb_llbit_value,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [RET_W-1:0]        retire_cnt
);

  logic [NCH-1:0]        r_valid;
  logic [NCH*ADDR_W-1:0] r_wd;
  logic [NCH-1:0]        r_wreg;
  logic [NCH*DATA_W-1:0] r_wdata;
  logic                  r_whilo;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_llbit_we;
  logic                  r_llbit_value;
  logic [CNT_W-1:0]      r_cnt;
  logic [RET_W-1:0]      r_retire;

  logic [NCH-1:0]        w_qual;
  logic [NCH-1:0]        w_wreg;
  logic [RET_W-1:0]      w_pop;
  logic                  w_any;
  logic                  w_bubble;
  logic                  w_capture;

  assign w_any     = |mem_valid;
  assign w_bubble  = stall[STAGE] & ~stall[STAGE+1];
  assign w_capture = ~stall[STAGE];

  // Qualify writes ($zero and invalid channels drop out), then let the highest channel win same-address collisions
  always_comb begin
    w_qual = '0;
    w_wreg = '0;
    for (int i = 0; i < NCH; i++) begin
      w_qual[i] = mem_valid[i] & mem_wreg[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
    end
    for (int i = 0; i < NCH; i++) begin
      w_wreg[i] = w_qual[i];
      for (int j = i + 1; j < NCH; j++) begin
        if (w_qual[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
          w_wreg[i] = 1'b0;
        end
      end
    end
  end

  // Number of real instructions in the group entering WB
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + {{(RET_W-1){1'b0}}, mem_valid[i]};
    end
  end

  // Pipeline register: reset > flush > bubble > capture > hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= '0;
      r_wd          <= '0;
      r_wreg        <= '0;
      r_wdata       <= '0;
      r_whilo       <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_llbit_we    <= 1'b0;
      r_llbit_value <= 1'b0;
      r_cnt         <= '0;
      r_retire      <= '0;
    end else if (flush || w_bubble) begin
      r_valid       <= '0;
      r_wd          <= '0;
      r_wreg        <= '0;
      r_wdata       <= '0;
      r_whilo       <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_llbit_we    <= 1'b0;
      r_llbit_value <= 1'b0;
      // a flush discards the multi-cycle progress, a bubble keeps it
      r_cnt         <= flush ? '0 : cnt_i;
    end else if (w_capture) begin
      r_valid       <= mem_valid;
      r_wd          <= mem_wd;
      r_wreg        <= w_wreg;
      r_wdata       <= mem_wdata;
      r_whilo       <= mem_whilo & w_any;
      r_hi          <= mem_hi;
      r_lo          <= mem_lo;
      r_llbit_we    <= mem_llbit_we & w_any;
      r_llbit_value <= mem_llbit_value;
      r_cnt         <= '0;
      r_retire      <= r_retire + w_pop;
    end else begin
      r_cnt         <= cnt_i;
    end
  end

  assign wb_valid       = r_valid;
  assign wb_wd          = r_wd;
  assign wb_wreg        = r_wreg;
  assign wb_wdata       = r_wdata;
  assign wb_whilo       = r_whilo;
  assign wb_hi          = r_hi;
  assign wb_lo          = r_lo;
  assign wb_llbit_we    = r_llbit_we;
  assign wb_llbit_value = r_llbit_value;
  assign cnt_o          = r_cnt;
  assign retire_cnt     = r_retire;

endmodule

// File: tb/tb_mem_wb_multi.sv
// tb/tb_mem_wb_multi.sv - self-checking bench for mem_wb_multi against a behavioural model
module tb_mem_wb_multi;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NCH     = 2;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;
  localparam int RET_W   = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [STALL_W-1:0]    stall;
  logic                  flush;
  logic [NCH-1:0]        mem_valid;
  logic [NCH*ADDR_W-1:0] mem_wd;
  logic [NCH-1:0]        mem_wreg;
  logic [NCH*DATA_W-1:0] mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic                  mem_llbit_we;
  logic                  mem_llbit_value;
  logic [CNT_W-1:0]      cnt_i;
  logic [NCH-1:0]        wb_valid;
  logic [NCH*ADDR_W-1:0] wb_wd;
  logic [NCH-1:0]        wb_wreg;
  logic [NCH*DATA_W-1:0] wb_wdata;
  logic                  wb_whilo;
  logic [DATA_W-1:0]     wb_hi;
  logic [DATA_W-1:0]     wb_lo;
  logic                  wb_llbit_we;
  logic                  wb_llbit_value;
  logic [CNT_W-1:0]      cnt_o;
  logic [RET_W-1:0]      retire_cnt;

  mem_wb_multi #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .RET_W(RET_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value), .cnt_i(cnt_i),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .cnt_o(cnt_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected state
  logic [NCH-1:0]        e_valid;
  logic [NCH*ADDR_W-1:0] e_wd;
  logic [NCH-1:0]        e_wreg;
  logic [NCH*DATA_W-1:0] e_wdata;
  logic                  e_whilo;
  logic [DATA_W-1:0]     e_hi;
  logic [DATA_W-1:0]     e_lo;
  logic                  e_llwe;
  logic                  e_llv;
  int                    e_cnt;
  int                    e_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    e_valid = '0; e_wd = '0; e_wreg = '0; e_wdata = '0;
    e_whilo = 1'b0; e_hi = '0; e_lo = '0; e_llwe = 1'b0; e_llv = 1'b0;
  endtask

  // Expected effect of one rising edge, from the documented rules
  task automatic model_edge();
    logic [ADDR_W-1:0] ai, aj;
    bit qi, qj, shadowed;
    if (flush) begin
      model_clear();
      e_cnt = 0;
    end else if (stall[STAGE] && !stall[STAGE+1]) begin
      model_clear();
      e_cnt = int'(cnt_i);
    end else if (!stall[STAGE]) begin
      e_valid = mem_valid;
      e_wd = mem_wd;
      e_wdata = mem_wdata;
      e_hi = mem_hi;
      e_lo = mem_lo;
      e_llv = mem_llbit_value;
      e_whilo = mem_whilo && (mem_valid != 0);
      e_llwe = mem_llbit_we && (mem_valid != 0);
      for (int i = 0; i < NCH; i++) begin
        ai = mem_wd[i*ADDR_W +: ADDR_W];
        qi = mem_valid[i] && mem_wreg[i] && (ai != 0);
        shadowed = 0;
        for (int j = i + 1; j < NCH; j++) begin
          aj = mem_wd[j*ADDR_W +: ADDR_W];
          qj = mem_valid[j] && mem_wreg[j] && (aj != 0);
          if (qj && aj == ai) shadowed = 1;
        end
        e_wreg[i] = qi && !shadowed;
      end
      e_cnt = 0;
      e_ret = (e_ret + $countones(mem_valid)) % (1 << RET_W);
    end else begin
      e_cnt = int'(cnt_i);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"}, 64'(wb_valid), 64'(e_valid));
    chk({ctx, ".wd"}, 64'(wb_wd), 64'(e_wd));
    chk({ctx, ".wreg"}, 64'(wb_wreg), 64'(e_wreg));
    chk({ctx, ".wdata"}, 64'(wb_wdata), 64'(e_wdata));
    chk({ctx, ".whilo"}, 64'(wb_whilo), 64'(e_whilo));
    chk({ctx, ".hi"}, 64'(wb_hi), 64'(e_hi));
    chk({ctx, ".lo"}, 64'(wb_lo), 64'(e_lo));
    chk({ctx, ".llwe"}, 64'(wb_llbit_we), 64'(e_llwe));
    chk({ctx, ".llv"}, 64'(wb_llbit_value), 64'(e_llv));
    chk({ctx, ".cnt"}, 64'(cnt_o), 64'(e_cnt));
    chk({ctx, ".retire"}, 64'(retire_cnt), 64'(e_ret));
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic set_inputs(input logic [NCH-1:0] v, input logic [NCH*ADDR_W-1:0] wd,
                            input logic [NCH-1:0] wr, input logic [NCH*DATA_W-1:0] wdat);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    set_inputs('0, '0, '0, '0);
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0; cnt_i = '0;
    model_clear(); e_cnt = 0; e_ret = 0;

    // reset state
    @(posedge clk); #1;
    check_all("reset");
    rst = 1'b1;

    // collision: both channels write $3, channel 1 wins
    set_inputs(2'b11, {5'd3, 5'd3}, 2'b11, {32'hB, 32'hA});
    mem_whilo = 1'b1; mem_hi = 32'h1111; mem_lo = 32'h2222;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    step("collide");
    chk("collide.wreg_const", 64'(wb_wreg), 64'b10);

    // $zero write and invalid channel suppressed
    set_inputs(2'b01, {5'd7, 5'd0}, 2'b11, {32'hDEAD, 32'hBEEF});
    mem_whilo = 1'b0; mem_llbit_we = 1'b0;
    step("zero");
    chk("zero.valid_const", 64'(wb_valid), 64'b01);

    // set up nonzero state, then bubble, hold, capture
    set_inputs(2'b11, {5'd9, 5'd4}, 2'b11, {32'h55, 32'h44});
    mem_whilo = 1'b1; mem_llbit_we = 1'b1;
    step("load");
    stall = 6'b010000; cnt_i = 2'd2;
    step("bubble");
    chk("bubble.cnt_const", 64'(cnt_o), 64'd2);
    set_inputs(2'b11, {5'd1, 5'd2}, 2'b11, {32'h77, 32'h66});
    step("load2_held_in_bubble");
    stall = 6'b110000; cnt_i = 2'd3;
    step("hold");
    chk("hold.cnt_const", 64'(cnt_o), 64'd3);
    stall = '0;
    step("capture");
    chk("capture.cnt_const", 64'(cnt_o), 64'd0);

    // flush beats stall
    flush = 1'b1; stall = 6'b010000; cnt_i = 2'd1;
    step("flush");
    flush = 1'b0; stall = '0;

    // asynchronous reset in the middle of a hold, with outputs nonzero
    set_inputs(2'b11, {5'd12, 5'd13}, 2'b01, {32'hCAFE, 32'hF00D});
    step("preload");
    stall = 6'b110000; cnt_i = 2'd3;
    step("hold2");
    #2;
    rst = 1'b0;
    #1;
    model_clear(); e_cnt = 0; e_ret = 0;
    check_all("async_reset");
    #3;
    rst = 1'b1;
    stall = '0;

    // retire counter wrap: bring it to 15, then add two
    set_inputs(2'b01, {5'd0, 5'd5}, 2'b01, {32'h0, 32'h5});
    for (int k = 0; k < 20 && e_ret != 15; k++) step("toward_wrap");
    chk("wrap.pre", 64'(retire_cnt), 64'd15);
    set_inputs(2'b11, {5'd6, 5'd5}, 2'b11, {32'h6, 32'h5});
    step("wrap");
    chk("wrap.post", 64'(retire_cnt), 64'd1);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      flush = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: stall = 6'b010000;
        1: stall = 6'b110000;
        default: stall = 6'(($urandom & 32'h2F));
      endcase
      mem_valid = NCH'($urandom);
      mem_wreg = NCH'($urandom);
      for (int i = 0; i < NCH; i++) mem_wd[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
      mem_wdata = {$urandom, $urandom};
      mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
      mem_llbit_we = 1'($urandom); mem_llbit_value = 1'($urandom);
      cnt_i = CNT_W'($urandom);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_wb_multi.md
# mem_wb_multi

Parametrised MEM/WB pipeline register for the multi-issue SammingCPU datapath. It carries NCH register-write channels plus the shared HI/LO, LL-bit and multi-cycle MEM counter from MEM to WB. It extends the single-channel stage with a flush input, per-channel valid bits and same-destination collision resolution. It also provides $zero write suppression and a retired-instruction counter. It sits between the MEM stage and the regfile / HI-LO / LLbit write ports; all outputs are registered.

## Interface
- DATA_W, 32, width of register / HI / LO data
- ADDR_W, 5, register address width
- NCH, 2, number of write channels (1..4)
- CNT_W, 2, width of MEM multi-cycle counter
- STALL_W, 6, stall vector width
- STAGE, 4, index of this stage's stall bit; STAGE+1 < STALL_W
- RET_W, 16, retire counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (rst == 0 resets)
- stall  in  STALL_W  pipeline stall vector from ctrl
- flush  in  1  exception flush; kills the instruction group entering WB
- mem_valid  in  NCH  channel i holds a real instruction
- mem_wd  in  NCH*ADDR_W  destination address, channel i at [i*ADDR_W +: ADDR_W]
- mem_wreg  in  NCH  register write enable per channel
- mem_wdata  in  NCH*DATA_W  write data, channel i at [i*DATA_W +: DATA_W]
- mem_whilo, mem_hi, mem_lo  in  1, DATA_W, DATA_W  HI/LO write request and values
- mem_llbit_we, mem_llbit_value  in  1, 1  LL/SC bit update
- cnt_i  in  CNT_W  MEM multi-cycle counter in
- wb_valid, wb_wd, wb_wreg, wb_wdata  out  NCH, NCH*ADDR_W, NCH, NCH*DATA_W  registered channel outputs
- wb_whilo, wb_hi, wb_lo  out  1, DATA_W, DATA_W  registered HI/LO write
- wb_llbit_we, wb_llbit_value  out  1, 1  registered LL-bit write
- cnt_o  out  CNT_W  counter returned to MEM
- retire_cnt  out  RET_W  count of retired valid channels

## Operation
- Priority per rising edge: reset > flush > bubble > capture > hold.
- Reset (rst low, async): every output 0 (wb_wd all 0 = NOPRegAddr, enables/valid 0, data 0, cnt_o 0, retire_cnt 0).
- Flush (flush=1): all enables, valid, data, addresses cleared to 0; cnt_o <= 0; retire_cnt unchanged. Applies regardless of stall.
- Bubble (stall[STAGE]=1, stall[STAGE+1]=0): same clearing as flush except cnt_o <= cnt_i.
- Capture (stall[STAGE]=0): all fields loaded from mem_*; cnt_o <= 0. Capture rules:
  - wb_valid[i] = mem_valid[i].
  - wb_wreg[i] = mem_valid[i] & mem_wreg[i] & (mem_wd_i != 0), suppressing $zero writes.
  - Collision: if channels i<j both qualify with equal mem_wd, wb_wreg[i] is cleared; the highest-indexed channel wins. wd/wdata are still captured.
  - wb_whilo = mem_whilo & |mem_valid.
  - wb_llbit_we = mem_llbit_we & |mem_valid.
  - Data and address captured unmasked.
  - retire_cnt += popcount(mem_valid), modulo 2^RET_W (wraps silently).
- Hold (stall[STAGE]=1, stall[STAGE+1]=1): all outputs keep their values; cnt_o <= cnt_i.

## Timing
- Latency one cycle: inputs at edge k appear on outputs after edge k.
- No combinational path from any input to any output.
- Reset deassertion is sampled at the next rising edge; reset asserted mid-stall clears everything immediately, without waiting for clk.
- flush and stall asserted together: flush wins, and cnt_o becomes 0, not cnt_i.
- retire_cnt increments are visible one cycle after capture; hold and bubble cycles add nothing.

## Test plan
- Reset: drive rst=0 mid-cycle with outputs nonzero -> all outputs 0 before the next edge; retire_cnt=0.
- Capture with NCH=2: valid=2'b11, wd={5'd3,5'd3}, wreg=2'b11, wdata={32'hB,32'hA} -> wb_wreg=2'b10, wb_wdata={B,A}, retire_cnt +2.
- $zero and invalid channels: ch0 wd=0 wreg=1 valid=1; ch1 valid=0 wreg=1 -> wb_wreg=2'b00, wb_valid=2'b01, retire_cnt +1.
- Bubble vs hold: stall=6'b010000, cnt_i=2'd2 -> enables 0, cnt_o=2. Then stall=6'b110000, cnt_i=2'd3 -> outputs unchanged, cnt_o=3. Then stall=0 -> capture, cnt_o=0.
- Flush priority: flush=1 with stall=6'b010000, cnt_i=2'd1 -> outputs 0, cnt_o=0, retire_cnt unchanged.
- Wrap: RET_W=4, preload retire_cnt=15, capture with valid=2'b11 -> retire_cnt=1.
